// File: rtl/uart_pkg.sv
// Shared 8N1 UART frame constants, used by both the transmit and receive ends.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int   DATA_BITS  = 8;     // payload bits per frame
    localparam int   FRAME_BITS = 10;    // start + data + stop
    localparam logic IDLE_LEVEL = 1'b1;  // line level between frames and during stop

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts while enabled and pulses bit_end on the last cycle of each bit.
// Latency: bit_end is asserted combinationally in the cycle where count == SYMBOL_EDGE_TIME-1.
// Backpressure: none; the owner gates progress with enable and restarts with clear.
//
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   enable    - advance the counter this cycle
//   clear     - force the counter back to zero (wins over enable)
//   bit_end   - one-cycle pulse on the final cycle of the current bit
module uart_bit_timer #(
    parameter int SYMBOL_EDGE_TIME = 1085,
    // Sized to hold 0..SYMBOL_EDGE_TIME-1; valid for any SYMBOL_EDGE_TIME >= 2.
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

    logic [CLOCK_COUNTER_WIDTH-1:0] count;

    assign bit_end = enable && (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            // Wrap at the bit boundary so each bit lasts exactly SYMBOL_EDGE_TIME cycles.
            count <= bit_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serializes accepted bytes as 8N1 frames on serial_out (idle high).
// Latency: start bit appears the cycle after accept; frame lasts FRAME_BITS*SYMBOL_EDGE_TIME cycles.
// Backpressure: data_in_ready is high only while idle; the byte is latched on the accept edge.
//
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   data_in        - byte to send, sampled only on the accept cycle
//   data_in_valid  - producer has a byte (fifo deq_valid)
//   data_in_ready  - transmitter idle and able to take a byte (fifo deq_ready)
//   serial_out     - registered TX line
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int IDX_W            = $clog2(DATA_BITS);

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   data_reg;
    logic [IDX_W-1:0]       bit_index;
    logic [IDX_W-1:0]       next_index;
    logic                   bit_end;

    assign data_in_ready = (state == IDLE);
    assign next_index    = bit_index + 1'b1;

    // The timer sits at zero while idle, so every frame starts on a fresh bit.
    uart_bit_timer #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .clear  (state == IDLE),
        .bit_end(bit_end)
    );

    // serial_out is loaded with the level of the state being entered, so the
    // pin is a plain flop output and changes exactly on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= IDLE_LEVEL;
            bit_index  <= '0;
            data_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= IDLE_LEVEL;
                    if (data_in_valid) begin
                        data_reg   <= data_in;
                        state      <= START;
                        serial_out <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        bit_index  <= '0;
                        serial_out <= data_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_index == LAST_INDEX) begin
                            state      <= STOP;
                            bit_index  <= '0;
                            serial_out <= IDLE_LEVEL;
                        end else begin
                            bit_index  <= next_index;
                            serial_out <= data_reg[next_index];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        serial_out <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: per-cycle line/ready model plus a mid-bit line decoder.
// Latency: n/a.
// Backpressure: the bench plays a fifo that pops only on modelled accepts.
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int CF        = 1000;
    localparam int BR        = 100;
    localparam int SET       = CF / BR;
    localparam int FRAME_CYC = FRAME_BITS * SET;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    uart_transmitter #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a frame is FRAME_CYC cycles; position p within it carries
    // bit p/SET of the sequence start(0), d0..d7, stop(1).
    bit         checks_on = 1'b0;
    bit         m_busy    = 1'b0;
    int         m_pos     = 0;
    logic [7:0] m_byte    = 8'h00;
    bit         took      = 1'b0;
    logic [7:0] exp_q[$];
    int         acc_q[$];

    // Independent mid-bit decoder of the TX line.
    bit         dec_busy  = 1'b0;
    int         dec_cnt   = 0;
    logic [7:0] dec_byte  = 8'h00;
    int         rx_count  = 0;

    logic [7:0] fifo[$];
    bit         fifo_mode = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int k;
        k = pos / SET;
        if (k == 0) return 1'b0;
        if (k <= DATA_BITS) return b[3'(k - 1)];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        int k;
        took = 1'b0;
        if (checks_on) begin
            check("ready", {31'b0, data_in_ready}, {31'b0, !m_busy});
            check("line", {31'b0, serial_out},
                  {31'b0, m_busy ? frame_bit(m_byte, m_pos) : 1'b1});
        end

        if (rst) begin
            dec_busy = 1'b0;
        end else if (checks_on) begin
            if (dec_busy) begin
                dec_cnt++;
                if (dec_cnt % SET == SET / 2) begin
                    k = dec_cnt / SET;
                    if (k <= DATA_BITS) begin
                        dec_byte[3'(k - 1)] = serial_out;
                    end else begin
                        check("stop_bit", {31'b0, serial_out}, 32'd1);
                        dec_busy = 1'b0;
                        rx_count++;
                        if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                        else check("rx_byte", {24'b0, dec_byte}, {24'b0, exp_q.pop_front()});
                    end
                end
            end else if (serial_out == 1'b0) begin
                dec_busy = 1'b1;
                dec_cnt  = 0;
            end
        end

        if (rst) begin
            // An aborted frame will never be decoded; drop it from the scoreboard.
            if (m_busy && m_pos < FRAME_CYC - SET / 2 && exp_q.size() > 0)
                void'(exp_q.pop_back());
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_pos == FRAME_CYC - 1) m_busy = 1'b0;
            else m_pos++;
        end else if (data_in_valid) begin
            m_busy = 1'b1;
            m_pos  = 0;
            m_byte = data_in;
            exp_q.push_back(data_in);
            acc_q.push_back(cyc);
            took = 1'b1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (fifo_mode) begin
            if (took && fifo.size() > 0) void'(fifo.pop_front());
            data_in_valid = (fifo.size() > 0);
            if (fifo.size() > 0) data_in = fifo[0];
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((fifo.size() > 0 || m_busy || data_in_valid) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check("drain_timeout", 32'd0, 32'd1);
        repeat (5) step();
    endtask

    initial begin
        int rx0;

        // Reset held three cycles, then a long idle stretch.
        rst = 1'b1;
        step();
        checks_on = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (50) step();

        // Single byte with a one-cycle valid pulse.
        rx0 = rx_count;
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        repeat (FRAME_CYC + 10) step();
        check("a5_frames", rx_count - rx0, 32'd1);

        // Back-to-back from the fifo.
        acc_q.delete();
        rx0 = rx_count;
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        fifo_mode = 1'b1;
        drain(4 * FRAME_CYC);
        fifo_mode = 1'b0;
        check("b2b_accepts", acc_q.size(), 32'd2);
        if (acc_q.size() >= 2)
            check("b2b_spacing", acc_q[1] - acc_q[0], FRAME_CYC + 1);
        check("b2b_frames", rx_count - rx0, 32'd2);

        // data_in and valid disturbed mid-frame.
        acc_q.delete();
        rx0 = rx_count;
        data_in = 8'h81;
        data_in_valid = 1'b1;
        step();
        data_in = 8'h3C;
        repeat (60) begin
            data_in_valid = 1'($urandom_range(0, 1));
            step();
        end
        data_in_valid = 1'b0;
        repeat (FRAME_CYC) step();
        check("midframe_accepts", acc_q.size(), 32'd1);
        check("midframe_frames", rx_count - rx0, 32'd1);

        // Reset during data bit 4, then a clean frame.
        rx0 = rx_count;
        data_in = 8'h55;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        repeat (55) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        data_in = 8'h12;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        repeat (FRAME_CYC + 10) step();
        check("post_reset_frames", rx_count - rx0, 32'd1);

        // Sixteen random bytes streamed from the fifo.
        rx0 = rx_count;
        for (int i = 0; i < 16; i++) fifo.push_back(8'($urandom_range(0, 255)));
        fifo_mode = 1'b1;
        drain(16 * (FRAME_CYC + 1) + 50);
        fifo_mode = 1'b0;
        check("stream_frames", rx_count - rx0, 32'd16);
        check("pending", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
